tblink_rpc_cmdinit: RTL

TBLINK_RPC_CMDINIT -- requirements
Module: tblink_rpc_cmdinit

---
 rtl/tblink_rpc_cmdinit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tblink_rpc_cmdinit.sv
// tblink_rpc_cmdinit: sends one command packet per toggle handshake and collects its tagged response.
module tblink_rpc_cmdinit #(
  parameter int CMD_PARAMS_SZ = 4,
  parameter int CMD_RSP_SZ = 4,
  parameter logic [7:0] DST_ID = 8'h00
) (
  input  logic                      uclock,
  input  logic                      reset_n,
  output logic [7:0]                req_dat,
  output logic                      req_valid,
  input  logic                      req_ready,
  input  logic [7:0]                rsp_dat,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [7:0]                cmd,
  input  logic [7:0]                cmd_sz,
  input  logic [CMD_PARAMS_SZ*8-1:0] cmd_params,
  input  logic                      cmd_put_i,
  output logic                      cmd_get_i,
  output logic [CMD_RSP_SZ*8-1:0]   cmd_rsp,
  output logic [7:0]                cmd_rsp_sz,
  output logic                      cmd_err,
  output logic                      rsp_drop
);
  typedef enum logic [3:0] {
    IDLE, TX_DST, TX_SZ, TX_CMD, TX_ID, TX_DAT,
    RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT
  } state_t;
  localparam logic [7:0] PSZ = 8'(CMD_PARAMS_SZ);
  localparam logic [7:0] RSZ = 8'(CMD_RSP_SZ);
  state_t state_q;
  logic [7:0] req_dat_q, rsp_sz_q, tag_q, cmd_q, n_q, rem_q, s_q, k_q;
  logic req_valid_q, get_q, err_q, drop_q, mis_q;
  logic [CMD_RSP_SZ*8-1:0] rsp_q;
  logic [CMD_PARAMS_SZ*8-1:0] params_q;
  logic rx_acc, last, mis_now;
  assign req_dat = req_dat_q;
  assign req_valid = req_valid_q;
  assign rsp_ready = state_q inside {RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT};
  assign cmd_get_i = get_q;
  assign cmd_rsp = rsp_q;
  assign cmd_rsp_sz = rsp_sz_q;
  assign cmd_err = err_q;
  assign rsp_drop = drop_q;
  assign rx_acc = rsp_valid && rsp_ready;
  // Final response byte and whether the packet it closes is foreign or malformed (S == 0).
  always_comb begin
    last = (state_q == RX_CMD && s_q == 8'd0) || (state_q == RX_ID && s_q == 8'd1) ||
           (state_q == RX_DAT && k_q == s_q - 8'd2);
    mis_now = mis_q || (state_q == RX_CMD && (rsp_dat != 8'd0 || s_q == 8'd0)) ||
              (state_q == RX_ID && rsp_dat != tag_q);
  end
  always_ff @(posedge uclock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_dat_q <= '0;
      req_valid_q <= 1'b0;
      get_q <= 1'b0;
      rsp_q <= '0;
      rsp_sz_q <= '0;
      err_q <= 1'b0;
      drop_q <= 1'b0;
      tag_q <= '0;
      cmd_q <= '0;
      params_q <= '0;
      n_q <= '0;
      rem_q <= '0;
      s_q <= '0;
      k_q <= '0;
      mis_q <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_put_i != get_q) begin
          if (cmd == 8'd0) begin
            err_q <= 1'b1;
            rsp_sz_q <= '0;
            get_q <= ~get_q;
          end else begin
            cmd_q <= cmd;
            params_q <= cmd_params;
            n_q <= (cmd_sz > PSZ) ? PSZ : cmd_sz;
            err_q <= 1'b0;
            rsp_q <= '0;
            req_dat_q <= DST_ID;
            req_valid_q <= 1'b1;
            state_q <= TX_DST;
          end
        end
        TX_DST: if (req_ready) begin
          req_dat_q <= n_q + 8'd1;
          state_q <= TX_SZ;
        end
        TX_SZ: if (req_ready) begin
          req_dat_q <= cmd_q;
          state_q <= TX_CMD;
        end
        TX_CMD: if (req_ready) begin
          req_dat_q <= tag_q;
          state_q <= TX_ID;
        end
        TX_ID, TX_DAT: if (req_ready) begin
          if ((state_q == TX_ID && n_q == 8'd0) || (state_q == TX_DAT && rem_q == 8'd0)) begin
            req_valid_q <= 1'b0;
            state_q <= RX_DST;
          end else begin
            req_dat_q <= params_q[7:0];
            params_q <= params_q >> 8;
            rem_q <= (state_q == TX_ID) ? n_q - 8'd1 : rem_q - 8'd1;
            state_q <= TX_DAT;
          end
        end
        RX_DST: if (rx_acc) begin
          mis_q <= 1'b0;
          state_q <= RX_SZ;
        end
        RX_SZ: if (rx_acc) begin
          s_q <= rsp_dat;
          state_q <= RX_CMD;
        end
        RX_CMD: if (rx_acc) begin
          mis_q <= mis_now;
          state_q <= RX_ID;
        end
        RX_ID: if (rx_acc) begin
          mis_q <= mis_now;
          k_q <= '0;
          state_q <= RX_DAT;
        end
        RX_DAT: if (rx_acc) begin
          for (int b = 0; b < CMD_RSP_SZ; b++)
            if (k_q == 8'(b)) rsp_q[8*b +: 8] <= rsp_dat;
          k_q <= k_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
      if (rx_acc && last) begin
        if (mis_now) begin
          drop_q <= 1'b1;
          rsp_q <= '0;
          state_q <= RX_DST;
        end else begin
          rsp_sz_q <= (s_q - 8'd1 > RSZ) ? RSZ : s_q - 8'd1;
          get_q <= ~get_q;
          tag_q <= tag_q + 8'd1;
          state_q <= IDLE;
        end
      end
    end
  end
endmodule
